// File: rtl/operand_loader.sv
// Operand loader: debounces two active-low buttons and steps x -> y -> op capture for the ALU.
// Latency: the FSM updates DEB_CYCLES+3 edges after a stable press. No backpressure. OPLOAD_ERR_EN adds the err output.

module operand_loader_debounce #(
  parameter int DEB_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_n,
  output logic press
);

  localparam int CW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;

  logic          sync1;
  logic          sync2;
  logic          level;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      level <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= raw_n;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 != level) begin
        // The level flips on the DEB_CYCLES-th consecutive differing sample.
        if (cnt == CW'(DEB_CYCLES - 1)) begin
          level <= sync2;
          cnt   <= '0;
          press <= ~sync2;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

module operand_loader #(
  parameter int WIDTH      = 8,
  parameter int DEB_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw,
  input  logic             btn_enter_n,
  input  logic             btn_clr_n,
  output logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y,
  output logic [2:0]       sel,
  output logic             valid,
  output logic [1:0]       state_led
`ifdef OPLOAD_ERR_EN
  ,
  output logic             err
`endif
);

  typedef enum logic [1:0] {
    S_X   = 2'b00,
    S_Y   = 2'b01,
    S_OP  = 2'b10,
    S_RUN = 2'b11
  } state_t;

  localparam logic [2:0] SEL_NONE = 3'b111;
  localparam logic [2:0] SEL_CMP  = 3'b110;
  localparam logic [2:0] SEL_ADD  = 3'b101;
  localparam logic [2:0] SEL_SUBT = 3'b011;

  state_t state;
  logic   enter_pulse;
  logic   clr_pulse;

  operand_loader_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_enter (
    .clk   (clk),
    .rst   (rst),
    .raw_n (btn_enter_n),
    .press (enter_pulse)
  );

  operand_loader_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_clr (
    .clk   (clk),
    .rst   (rst),
    .raw_n (btn_clr_n),
    .press (clr_pulse)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_X;
      x     <= '0;
      y     <= '0;
      sel   <= SEL_NONE;
      valid <= 1'b0;
`ifdef OPLOAD_ERR_EN
      err   <= 1'b0;
`endif
    end else begin
`ifdef OPLOAD_ERR_EN
      err <= 1'b0;
`endif
      // Clear outranks enter; a coincident enter is dropped.
      if (clr_pulse) begin
        state <= S_X;
        x     <= '0;
        y     <= '0;
        sel   <= SEL_NONE;
        valid <= 1'b0;
      end else if (enter_pulse) begin
        case (state)
          S_X: begin
            x     <= sw;
            state <= S_Y;
          end
          S_Y: begin
            y     <= sw;
            state <= S_OP;
          end
          S_OP: begin
            case (sw[1:0])
              2'b01: begin
                sel   <= SEL_CMP;
                valid <= 1'b1;
                state <= S_RUN;
              end
              2'b10: begin
                sel   <= SEL_ADD;
                valid <= 1'b1;
                state <= S_RUN;
              end
              2'b11: begin
                sel   <= SEL_SUBT;
                valid <= 1'b1;
                state <= S_RUN;
              end
              default: begin
`ifdef OPLOAD_ERR_EN
                err <= 1'b1;
`endif
              end
            endcase
          end
          default: begin
            sel   <= SEL_NONE;
            valid <= 1'b0;
            state <= S_X;
          end
        endcase
      end
    end
  end

  assign state_led = state;

endmodule

// File: tb/tb_operand_loader.sv
// Self-checking bench for operand_loader: directed scenarios plus random button traffic against a reference model.
module tb_operand_loader;

  localparam int DEB = 4;

  logic       clk;
  logic       rst;
  logic [7:0] sw;
  logic       btn_enter_n;
  logic       btn_clr_n;
  logic [7:0] x;
  logic [7:0] y;
  logic [2:0] sel;
  logic       valid;
  logic [1:0] state_led;
  logic       err_obs;

  int n_assert = 0;
  int n_fail   = 0;

`ifdef OPLOAD_ERR_EN
  logic err;
  assign err_obs = err;
`else
  assign err_obs = 1'b0;
`endif

  operand_loader #(.WIDTH(8), .DEB_CYCLES(DEB)) dut (
    .clk         (clk),
    .rst         (rst),
    .sw          (sw),
    .btn_enter_n (btn_enter_n),
    .btn_clr_n   (btn_clr_n),
    .x           (x),
    .y           (y),
    .sel         (sel),
    .valid       (valid),
    .state_led   (state_led)
`ifdef OPLOAD_ERR_EN
    ,
    .err         (err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: buttons as sample windows, FSM as plain state numbers.
  logic       m_s1 [2];
  logic       m_s2 [2];
  logic       m_lvl [2];
  logic       m_pe, m_pc;
  logic       q_e [$];
  logic       q_c [$];
  int         m_st;
  logic [7:0] m_x, m_y;
  logic [2:0] m_sel;
  logic       m_valid, m_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic deb_model(input logic s2, inout logic lvl, inout logic q [$], output logic p);
    logic flip;
    p = 1'b0;
    q.push_back(s2);
    if (q.size() > DEB) void'(q.pop_front());
    flip = (q.size() == DEB);
    foreach (q[i]) if (q[i] == lvl) flip = 1'b0;
    if (flip) begin
      lvl = s2;
      p   = ~s2;
      q.delete();
    end
  endtask

  task automatic model_edge();
    logic npe, npc;
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        m_s1[b] = 1'b1; m_s2[b] = 1'b1; m_lvl[b] = 1'b1;
      end
      q_e.delete(); q_c.delete();
      m_pe = 0; m_pc = 0; m_st = 0;
      m_x = 0; m_y = 0; m_sel = 3'b111; m_valid = 0; m_err = 0;
    end else begin
      m_err = 0;
      if (m_pc) begin
        m_st = 0; m_x = 0; m_y = 0; m_sel = 3'b111; m_valid = 0;
      end else if (m_pe) begin
        if (m_st == 0) begin
          m_x = sw; m_st = 1;
        end else if (m_st == 1) begin
          m_y = sw; m_st = 2;
        end else if (m_st == 2) begin
          if (sw[1:0] == 2'b00) m_err = 1;
          else begin
            m_sel   = ~(3'b001 << (sw[1:0] - 2'd1));
            m_valid = 1;
            m_st    = 3;
          end
        end else begin
          m_sel = 3'b111; m_valid = 0; m_st = 0;
        end
      end
      deb_model(m_s2[0], m_lvl[0], q_e, npe);
      deb_model(m_s2[1], m_lvl[1], q_c, npc);
      m_s2[0] = m_s1[0]; m_s1[0] = btn_enter_n;
      m_s2[1] = m_s1[1]; m_s1[1] = btn_clr_n;
      m_pe = npe; m_pc = npc;
    end
  endtask

  task automatic cyc(input logic e_n, input logic c_n, input logic [7:0] s, input logic r);
    btn_enter_n = e_n; btn_clr_n = c_n; sw = s; rst = r;
    @(posedge clk);
    model_edge();
    #1;
    chk("model", {10'd0, x, y, sel, valid, state_led},
        {10'd0, m_x, m_y, m_sel, m_valid, m_st[1:0]});
`ifdef OPLOAD_ERR_EN
    chk("model_err", {31'd0, err_obs}, {31'd0, m_err});
`endif
  endtask

  task automatic hold(input logic e_n, input logic c_n, input logic [7:0] s, input int n);
    for (int i = 0; i < n; i++) cyc(e_n, c_n, s, 1'b0);
  endtask

  // Held press: FSM must be unchanged after edge 6 and advanced after edge 7.
  task automatic press(input logic [7:0] s, input logic [1:0] st0, input logic [1:0] st1, input logic exp_err);
    for (int k = 1; k <= 7; k++) begin
      cyc(1'b0, 1'b1, s, 1'b0);
      if (k == 6) chk("edge6_state", {30'd0, state_led}, {30'd0, st0});
      if (k == 7) begin
        chk("edge7_state", {30'd0, state_led}, {30'd0, st1});
`ifdef OPLOAD_ERR_EN
        chk("edge7_err", {31'd0, err_obs}, {31'd0, exp_err});
`endif
      end
    end
    hold(1'b1, 1'b1, s, 7);
  endtask

  initial begin
    int len;
    logic e_n, c_n, r;
    logic [7:0] s;
    rst = 1'b1; btn_enter_n = 1'b1; btn_clr_n = 1'b1; sw = 8'h00;

    cyc(1, 1, 8'h00, 1);
    cyc(1, 1, 8'h00, 1);
    chk("rst_outs", {10'd0, x, y, sel, valid, state_led}, {10'd0, 8'h00, 8'h00, 3'b111, 1'b0, 2'b00});

    press(8'h3C, 2'b00, 2'b01, 1'b0);
    press(8'h15, 2'b01, 2'b10, 1'b0);
    press(8'h02, 2'b10, 2'b11, 1'b0);
    chk("load_outs", {10'd0, x, y, sel, valid, state_led}, {10'd0, 8'h3C, 8'h15, 3'b101, 1'b1, 2'b11});

    press(8'h00, 2'b11, 2'b00, 1'b0);
    chk("run_exit_hold", {16'd0, x, y}, {16'd0, 8'h3C, 8'h15});

    hold(0, 1, 8'h77, 3);
    hold(1, 1, 8'h77, 1);
    hold(0, 1, 8'h77, 3);
    hold(1, 1, 8'h77, 7);
    chk("bounce_state", {30'd0, state_led}, 32'd0);
    hold(0, 1, 8'h77, 6);
    chk("hold_pre", {30'd0, state_led}, 32'd0);
    hold(0, 1, 8'h77, 1);
    chk("hold_adv", {22'd0, x, state_led}, {22'd0, 8'h77, 2'b01});
    hold(0, 1, 8'h77, 13);
    chk("hold_norepeat", {30'd0, state_led}, 32'd1);
    hold(1, 1, 8'h77, 7);

    press(8'h99, 2'b01, 2'b10, 1'b0);
    press(8'hFC, 2'b10, 2'b10, 1'b1);
    chk("bad_op", {28'd0, sel, valid}, {28'd0, 3'b111, 1'b0});
    press(8'h03, 2'b10, 2'b11, 1'b0);
    chk("subt_op", {28'd0, sel, valid}, {28'd0, 3'b011, 1'b1});

    hold(1, 0, 8'h00, 7);
    hold(1, 1, 8'h00, 7);
    chk("clear_outs", {10'd0, x, y, sel, valid, state_led}, {10'd0, 8'h00, 8'h00, 3'b111, 1'b0, 2'b00});
    press(8'hAA, 2'b00, 2'b01, 1'b0);
    press(8'h55, 2'b01, 2'b10, 1'b0);
    press(8'h01, 2'b10, 2'b11, 1'b0);
    chk("cmp_load", {10'd0, x, y, sel, valid, state_led}, {10'd0, 8'hAA, 8'h55, 3'b110, 1'b1, 2'b11});
    hold(0, 0, 8'h02, 7);
    chk("clr_priority", {10'd0, x, y, sel, valid, state_led}, {10'd0, 8'h00, 8'h00, 3'b111, 1'b0, 2'b00});
    hold(1, 1, 8'h02, 7);

    hold(0, 1, 8'h42, 3);
    cyc(0, 1, 8'h42, 1);
    hold(0, 1, 8'h42, 6);
    chk("rst_mid_pre", {30'd0, state_led}, 32'd0);
    hold(0, 1, 8'h42, 1);
    chk("rst_mid_adv", {22'd0, x, state_led}, {22'd0, 8'h42, 2'b01});
    hold(0, 1, 8'h42, 8);
    chk("rst_mid_single", {30'd0, state_led}, 32'd1);
    hold(1, 1, 8'h42, 7);

    for (int it = 0; it < 400; it++) begin
      e_n = ($urandom_range(0, 99) < 45) ? 1'b0 : 1'b1;
      c_n = ($urandom_range(0, 99) < 12) ? 1'b0 : 1'b1;
      s   = 8'($urandom);
      len = $urandom_range(1, 12);
      for (int k = 0; k < len; k++) begin
        r = ($urandom_range(0, 199) == 0);
        if ($urandom_range(0, 3) == 0) s = 8'($urandom);
        cyc(e_n, c_n, s, r);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/operand_loader.md
Name: operand_loader

Overview:
- Upstream entry stage for the 8-bit ALU.
- Takes raw board switches and two raw active-low push-buttons. Debounces the buttons and steps an FSM that captures operand x, then operand y, then the operation code.
- Presents registered x, y and an active-low one-hot sel to the ALU, plus a valid flag and state LEDs.

Parameters:
- WIDTH, 8, operand width; also the width of sw, x and y.
- DEB_CYCLES, 50000, number of consecutive clk cycles a synchronized button level must differ from the debounced level before the debounced level flips. Minimum 2.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- sw  input  WIDTH  raw slide switches; not synchronized; sampled only on an enter-press cycle.
- btn_enter_n  input  1  raw enter button, 0 = pressed.
- btn_clr_n  input  1  raw clear button, 0 = pressed.
- x  output  WIDTH  captured operand x, registered.
- y  output  WIDTH  captured operand y, registered.
- sel  output  3  active-low one-hot op select: 110 = cmp, 101 = add, 011 = subt, 111 = none.
- valid  output  1  high while x, y and sel form a complete operation.
- state_led  output  2  current FSM state encoding.

Behaviour:
- Clocking and reset
  - One clock. Reset is synchronous and active-high: rst is sampled on the rising edge of clk.
  - rst has priority over all other logic.
- Reset values
  - x = 0, y = 0, sel = 3'b111, valid = 0, state = S_X (state_led = 00).
  - Both synchronizer flops = 1; both debounced levels = 1 (released); debounce counters = 0; press pulses = 0.
- Debouncer (one instance per button, identical)
  - 2-flop synchronizer on the raw input.
  - The counter increments each cycle the synchronized value differs from the debounced level, and clears to 0 on any cycle they are equal.
  - When the counter equals DEB_CYCLES-1 and the values still differ, the debounced level takes the synchronized value at that edge and the counter clears.
  - A press pulse (registered, exactly 1 cycle) asserts the cycle after the debounced level goes 1->0.
  - Release (0->1) generates no pulse. Holding a button produces one pulse only; no auto-repeat.
  - A glitch shorter than DEB_CYCLES synchronized cycles produces no pulse.
- Latency
  - Raw button low, first sampled at edge E1 and stable thereafter:
    - debounced level flips at edge E(DEB_CYCLES+2);
    - press pulse is high after that edge;
    - FSM registers update at edge E(DEB_CYCLES+3).
- FSM states (state_led encoding)
  - S_X = 00, S_Y = 01, S_OP = 10, S_RUN = 11.
  - S_X, enter pulse: x <= sw; go to S_Y.
  - S_Y, enter pulse: y <= sw; go to S_OP.
  - S_OP, enter pulse: decode sw[1:0].
    - 01 -> sel = 110; 10 -> sel = 101; 11 -> sel = 011. In each case valid <= 1 and go to S_RUN.
    - 00 -> invalid: no state change, sel stays 111.
  - S_RUN, enter pulse: sel <= 111, valid <= 0, go to S_X. x and y hold until overwritten.
  - Clear pulse, any state: x <= 0, y <= 0, sel <= 111, valid <= 0, go to S_X.
- Boundary conditions
  - Clear and enter pulses on the same cycle: clear wins; enter is discarded.
  - sw bits above [1:0] are ignored in S_OP.
  - sw changing while no pulse is present has no effect.
  - rst mid-debounce discards the partial count; no pulse follows the reset.
  - valid is high only in S_RUN. sel != 111 only in S_RUN.

Optional Feature:
- Macro: OPLOAD_ERR_EN.
- Defined:
  - Adds output port err (1 bit, reset 0).
  - err pulses high for exactly 1 cycle, on the edge where the FSM would have updated, when an enter pulse arrives in S_OP with sw[1:0] = 00.
  - If clear arrives on the same cycle, clear wins and err stays 0.
- Undefined: port err does not exist; invalid op codes are silently ignored.

Test Plan:
- Reset: assert rst 2 cycles with buttons released -> x = 00, y = 00, sel = 111, valid = 0, state_led = 00.
- Full load (DEB_CYCLES = 4): three enter presses with sw = 8'h3C, then 8'h15, then 8'h02 -> x = 3C, y = 15, sel = 101, valid = 1, state_led = 11.
  - Each FSM update lands exactly at edge 7 of the held press (DEB_CYCLES+3).
- Bounce rejection: enter low for 3 cycles, high for 1, low for 3 -> no state change; then hold low for 10 cycles -> exactly one advance; no repeat while held.
- Invalid op: in S_OP press with sw[1:0] = 00 -> stays in S_OP, sel = 111.
  - OPLOAD_ERR_EN defined: err high 1 cycle.
  - Then press with sw[1:0] = 11 -> sel = 011, valid = 1.
- Clear priority: in S_RUN with x = AA, y = 55, make enter and clear pulses coincide -> x = 00, y = 00, sel = 111, valid = 0, state_led = 00.
- Reset mid-debounce: enter held low 3 cycles, rst for 1 cycle, enter kept low -> state stays S_X until a full DEB_CYCLES+3 window after reset completes, then a single advance to S_Y.
